// File: rtl/rr_priority_arbiter8.sv
// Eight-requester arbiter with fixed-priority or round-robin selection, a hold limit
// per grant, and a mandatory one-cycle gap between consecutive grants.
module rr_priority_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       rel,
    input  logic       mode,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    last_id;

    logic [2:0]    win_c;
    logic          any_req_c;
    logic          drop_c;
    logic          limit_c;

    // Winner: highest index in fixed mode; in round-robin, descend from last_id-1 so last_id comes last
    always_comb begin
        logic [2:0] idx;
        logic       found;
        win_c = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        if (!mode) begin
            for (int i = 0; i < 8; i++) begin
                if (req[i]) win_c = 3'(i);
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                idx = last_id - 3'(k);
                if (!found && req[idx]) begin
                    win_c = idx;
                    found = 1'b1;
                end
            end
        end
    end

    assign any_req_c = |req;
    assign drop_c    = !req[gnt_id];
    assign limit_c   = (hold_cnt == HW'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 8'd0;
            gnt_id   <= 3'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
            last_id  <= 3'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (any_req_c) begin
                        state    <= GRANT;
                        gnt      <= 8'd1 << win_c;
                        gnt_id   <= win_c;
                        busy     <= 1'b1;
                        hold_cnt <= HW'(1);
                        last_id  <= win_c;
                    end else begin
                        state    <= IDLE;
                        gnt      <= 8'd0;
                        gnt_id   <= 3'd0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel || drop_c || limit_c) begin
                        state    <= GAP;
                        gnt      <= 8'd0;
                        gnt_id   <= 3'd0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                        // Release or a dropped request outranks the hold limit
                        timeout  <= limit_c && !rel && !drop_c;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= 8'd0;
                    gnt_id   <= 3'd0;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_priority_arbiter8.sv
// Directed bench for rr_priority_arbiter8: one task per scenario, expected values worked out by hand.
module tb_rr_priority_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rel;
    logic       mode;
    logic [7:0] gnt,  gnt1;
    logic [2:0] gnt_id, gnt_id1;
    logic       busy, busy1;
    logic       timeout, timeout1;

    int total = 0;
    int bad   = 0;

    rr_priority_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    rr_priority_arbiter8 #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .rel(rel), .mode(mode),
        .gnt(gnt1), .gnt_id(gnt_id1), .busy(busy1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_idle();
        req = 8'h00;
        rel = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 8'h00; rel = 1'b0; mode = 1'b0;
        #2;
        total++; if (gnt !== 8'h00)   begin bad++; $display("FAIL reset_gnt got=%h exp=00", gnt); end
        total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL reset_gnt_id got=%0d exp=0", gnt_id); end
        total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b timeout=%b exp=0 0", busy, timeout); end
        step();
        #2 rst_n = 1'b1;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_req busy=%b exp=0", busy); end
    endtask

    task automatic test_fixed();
        mode = 1'b0; req = 8'b1001_0000; rel = 1'b0;
        step();
        total++; if (gnt !== 8'h80 || gnt_id !== 3'd7 || busy !== 1'b1) begin bad++; $display("FAIL fixed_first gnt=%h id=%0d busy=%b exp=80 7 1", gnt, gnt_id, busy); end
        rel = 1'b1;
        step();
        total++; if (gnt !== 8'h00 || gnt_id !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL fixed_gap gnt=%h id=%0d busy=%b to=%b exp=00 0 0 0", gnt, gnt_id, busy, timeout); end
        rel = 1'b0;
        step();
        total++; if (gnt !== 8'h80 || gnt_id !== 3'd7) begin bad++; $display("FAIL fixed_regrant gnt=%h id=%0d exp=80 7", gnt, gnt_id); end
        to_idle();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_id [4];
        exp_id[0] = 3'd6; exp_id[1] = 3'd2; exp_id[2] = 3'd6; exp_id[3] = 3'd2;
        mode = 1'b1; req = 8'b0100_0100; rel = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            total++; if (gnt_id !== exp_id[n] || gnt !== (8'd1 << exp_id[n]) || busy !== 1'b1) begin bad++; $display("FAIL rr_grant%0d id=%0d gnt=%h exp_id=%0d", n, gnt_id, gnt, exp_id[n]); end
            step();
            total++; if (gnt !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL rr_gap%0d gnt=%h busy=%b exp=00 0", n, gnt, busy); end
        end
        to_idle();
    endtask

    task automatic test_timeout();
        mode = 1'b0; req = 8'h02; rel = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            total++; if (gnt_id !== 3'd1 || busy !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL hold_cycle%0d id=%0d busy=%b to=%b exp=1 1 0", n, gnt_id, busy, timeout); end
            if (n == 0) begin
                total++; if (gnt_id1 !== 3'd1 || busy1 !== 1'b1) begin bad++; $display("FAIL mh1_grant id=%0d busy=%b exp=1 1", gnt_id1, busy1); end
            end
            if (n == 1) begin
                total++; if (busy1 !== 1'b0 || timeout1 !== 1'b1) begin bad++; $display("FAIL mh1_gap busy=%b to=%b exp=0 1", busy1, timeout1); end
            end
            if (n == 2) begin
                total++; if (gnt1 !== 8'h02 || busy1 !== 1'b1) begin bad++; $display("FAIL mh1_regrant gnt=%h busy=%b exp=02 1", gnt1, busy1); end
            end
        end
        step();
        total++; if (busy !== 1'b0 || timeout !== 1'b1 || gnt !== 8'h00) begin bad++; $display("FAIL timeout_gap busy=%b to=%b gnt=%h exp=0 1 00", busy, timeout, gnt); end
        step();
        total++; if (gnt_id !== 3'd1 || busy !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL timeout_regrant id=%0d busy=%b to=%b exp=1 1 0", gnt_id, busy, timeout); end
        to_idle();
    endtask

    task automatic test_collision();
        mode = 1'b0; req = 8'h02; rel = 1'b0;
        repeat (4) step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL collision_hold busy=%b exp=1", busy); end
        rel = 1'b1;
        step();
        total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL collision_gap busy=%b to=%b exp=0 0", busy, timeout); end
        to_idle();
    endtask

    task automatic test_drop();
        mode = 1'b0; req = 8'b0011_0000; rel = 1'b0;
        step();
        total++; if (gnt_id !== 3'd5) begin bad++; $display("FAIL drop_first id=%0d exp=5", gnt_id); end
        req = 8'b1011_0000;
        step();
        total++; if (gnt !== 8'h20 || busy !== 1'b1) begin bad++; $display("FAIL drop_ignore_other gnt=%h busy=%b exp=20 1", gnt, busy); end
        req = 8'b0001_0000;
        step();
        total++; if (busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL drop_gap busy=%b to=%b exp=0 0", busy, timeout); end
        step();
        total++; if (gnt_id !== 3'd4 || gnt !== 8'h10) begin bad++; $display("FAIL drop_next id=%0d gnt=%h exp=4 10", gnt_id, gnt); end
        to_idle();
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; req = 8'h10; rel = 1'b0;
        step();
        total++; if (gnt_id !== 3'd4 || busy !== 1'b1) begin bad++; $display("FAIL midrst_pre id=%0d busy=%b exp=4 1", gnt_id, busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (gnt !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin bad++; $display("FAIL midrst_async gnt=%h busy=%b to=%b exp=00 0 0", gnt, busy, timeout); end
        step();
        #2 rst_n = 1'b1;
        req = 8'hFF; mode = 1'b1;
        step();
        total++; if (gnt_id !== 3'd7 || gnt !== 8'h80 || timeout !== 1'b0) begin bad++; $display("FAIL midrst_rr_first id=%0d gnt=%h to=%b exp=7 80 0", gnt_id, gnt, timeout); end
        to_idle();
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_timeout();
        test_collision();
        test_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter8.md
RR_PRIORITY_ARBITER8 -- requirements
Module: rr_priority_arbiter8

Interface
REQ-001 SHALL have parameter: MAX_HOLD, default 16, maximum consecutive GRANT cycles per grant (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  8  request vector, bit i = requester i.
REQ-005 SHALL have port: rel  input  1  release from the current holder.
REQ-006 SHALL have port: mode  input  1  0 = fixed priority, 1 = round-robin.
REQ-007 SHALL have port: gnt  output  8  one-hot grant, all zero when not granting.
REQ-008 SHALL have port: gnt_id  output  3  binary index of the granted requester.
REQ-009 SHALL have port: busy  output  1  high while in GRANT.
REQ-010 SHALL have port: timeout  output  1  one-cycle pulse, grant revoked by MAX_HOLD.
REQ-011 SHALL register all outputs; no combinational path from inputs to outputs.

Function
REQ-012 SHALL implement three states: IDLE, GRANT, GAP.
REQ-013 SHALL select the winner in fixed mode as the highest set index of req (bit 7 highest priority).
REQ-014 SHALL select the winner in round-robin mode by searching descending from last_id-1, wrapping 0->7, with last_id (the last granted index) searched last.
REQ-015 SHALL update last_id on every new grant, in both modes.
REQ-016 SHALL, in IDLE, on an edge with req != 0, enter GRANT with gnt = winner one-hot, gnt_id = winner, busy = 1 (one-cycle latency); with req == 0, stay in IDLE.
REQ-017 SHALL count GRANT cycles in hold_cnt, set to 1 on the first GRANT cycle, width ceil(log2(MAX_HOLD+1)).
REQ-018 SHALL, in GRANT, exit to GAP on the edge where rel == 1, or req[gnt_id] == 0, or hold_cnt == MAX_HOLD.
REQ-019 SHALL otherwise hold the grant unchanged and increment hold_cnt.
REQ-020 SHALL assert timeout during the GAP cycle only when the exit was caused solely by hold_cnt == MAX_HOLD.
REQ-021 SHALL treat rel, or a dropped req[gnt_id], as having precedence over timeout on the same edge, giving timeout = 0.
REQ-022 SHALL hold gnt = 0, gnt_id = 0, busy = 0 for exactly one GAP cycle.
REQ-023 SHALL arbitrate at the end of GAP: if req != 0, enter GRANT with the new winner, otherwise enter IDLE.
REQ-024 SHALL ignore rel in IDLE and GAP.
REQ-025 SHALL ignore changes to req bits other than gnt_id while in GRANT.
REQ-026 SHALL sample mode only at arbitration points, so a change during GRANT takes effect at the next arbitration.
REQ-027 SHALL, with MAX_HOLD = 1, grant for exactly one cycle per arbitration.

Reset
REQ-028 SHALL, while rst_n == 0 and without waiting for a clock edge, force state = IDLE, gnt = 0, gnt_id = 0, busy = 0, timeout = 0, hold_cnt = 0, last_id = 0.
REQ-029 SHALL abort any grant in progress on a mid-operation reset, with no timeout pulse.
REQ-030 SHALL treat the first edge after rst_n rises as a normal IDLE edge.
REQ-031 SHALL, with last_id = 0, use round-robin search order 7..0, so the first round-robin grant equals the fixed-priority result.

Verification
REQ-032 SHALL cover fixed priority: mode=0, req=8'b10010000 held, rel pulsed -> gnt=8'b10000000, gnt_id=7, then after the GAP cycle gnt_id=7 again (bit 4 starved).
REQ-033 SHALL cover round-robin: mode=1, req=8'b01000100 held, rel=1 on each grant's first cycle -> gnt_id sequence 6,2,6,2, with one gnt=0 cycle between grants.
REQ-034 SHALL cover timeout: MAX_HOLD=4, req=8'h02 held, rel=0 -> gnt_id=1 and busy=1 for 4 cycles, then GAP with timeout=1, then re-grant to 1.
REQ-035 SHALL cover release/timeout collision: MAX_HOLD=4, rel=1 on the 4th GRANT cycle -> GAP entered with timeout=0.
REQ-036 SHALL cover requester drop: req[gnt_id] deasserted mid-grant with rel=0 -> GAP next cycle, timeout=0, next winner chosen from the remaining requests.
REQ-037 SHALL cover reset mid-grant: rst_n low between edges during GRANT -> gnt=0 and busy=0 immediately; after release, mode=1, req=8'hFF -> gnt_id=7.
